// File: rtl/spi_pkg.sv
// Shared types for the SPI master.
//   state_t    : controller states (IDLE, SETUP, XFER, HOLD, GAP)
//   spi_mode_t : per-frame transfer mode, latched when a frame is accepted
//   cs_width() : width of a chip-select index for a given chip-select count
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    XFER  = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb_first;
  } spi_mode_t;

  // A single chip select still gets a 1-bit select field.
  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period divider for the SPI master.
//   clk, rst : system clock, asynchronous active-high reset
//   clear    : hold the count at zero (no tick while asserted)
//   div      : terminal count; one tick every div+1 clk cycles
//   tick     : one-cycle pulse on the cycle the count wraps
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear || (cnt_q >= div)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = !clear && (cnt_q >= div);

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master with multi-word frames.
//   clk, rst        : system clock, asynchronous active-high reset
//   cfg_*           : divider, mode and chip select; sampled only when a frame
//                     starts (accept in IDLE) and held for the whole frame
//   tx_valid/ready  : word input stream, tx_last closes the frame
//   rx_valid/data   : one-cycle pulse with each received word (no back-pressure)
//   busy            : high whenever the controller is not in IDLE
//   spi_clk/mosi/miso/cs_n : SPI pins (miso is assumed already synchronised)
//
// Handshake: a word transfers on every rising clk edge where tx_valid and
// tx_ready are both high. tx_ready does not depend on tx_valid; it is high in
// IDLE (after reset release) and in HOLD of a frame that has not seen tx_last.
// The source must keep tx_valid/tx_data/tx_last stable until the transfer.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2,
  parameter int DIV_W  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DIV_W-1:0]            cfg_div,
  input  logic                        cfg_cpol,
  input  logic                        cfg_cpha,
  input  logic                        cfg_lsb_first,
  input  logic [cs_width(NUM_CS)-1:0] cfg_cs_sel,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_last,
  output logic                        rx_valid,
  output logic [DATA_W-1:0]           rx_data,
  output logic                        busy,
  output logic                        spi_clk,
  output logic                        spi_mosi,
  input  logic                        spi_miso,
  output logic [NUM_CS-1:0]           spi_cs_n
);

  localparam int CS_W = cs_width(NUM_CS);
  localparam int BC_W = $clog2(DATA_W);

  state_t              state_q, state_d;
  spi_mode_t           mode_q, eff_mode;
  logic [DIV_W-1:0]    div_q;
  logic [CS_W-1:0]     cs_sel_q;
  logic                last_q;
  logic                ready_en_q;
  logic                sclk_q, mosi_q;
  logic [DATA_W-1:0]   tx_sr, rx_sr, rx_data_q, load_word;
  logic [BC_W-1:0]     bit_cnt_q;
  logic                phase_q;     // 0: next tick is a leading edge
  logic                rx_pend_q;
  logic                rx_valid_q;
  logic                tick, div_clear, cs_active, accept, last_edge;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) r[i] = d[DATA_W-1-i];
    return r;
  endfunction

  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk   (clk),
    .rst   (rst),
    .clear (div_clear),
    .div   (div_q),
    .tick  (tick)
  );

  assign accept    = tx_valid && tx_ready;
  // Trailing edge of the last bit ends the word.
  assign last_edge = tick && phase_q && (bit_cnt_q == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (tick) state_d = XFER;
      XFER:  if (last_edge) state_d = HOLD;
      HOLD: begin
        if (last_q) begin
          if (tick) state_d = GAP;
        end else if (accept) begin
          state_d = SETUP;
        end
      end
      GAP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    tx_ready  = 1'b0;
    busy      = 1'b1;
    cs_active = 1'b0;
    div_clear = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready  = ready_en_q;
        busy      = 1'b0;
        div_clear = 1'b1;
      end
      SETUP, XFER: cs_active = 1'b1;
      HOLD: begin
        cs_active = 1'b1;
        tx_ready  = !last_q;
        // Waiting for the next word: restart H from zero when it arrives.
        div_clear = !last_q;
      end
      GAP: ;
      default: ;
    endcase
  end

  // A frame's mode comes from cfg_* at the IDLE accept; later words reuse it.
  always_comb begin
    eff_mode = mode_q;
    if (state_q == IDLE) eff_mode = spi_mode_t'({cfg_cpol, cfg_cpha, cfg_lsb_first});
  end

  // Shift registers always move MSB-first; LSB-first is a reversal at the edges.
  assign load_word = eff_mode.lsb_first ? bit_rev(tx_data) : tx_data;

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      mode_q     <= '0;
      div_q      <= '0;
      cs_sel_q   <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt_q  <= '0;
      phase_q    <= 1'b0;
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      ready_en_q <= 1'b1;
      rx_valid_q <= 1'b0;

      if (rx_pend_q) begin
        rx_pend_q  <= 1'b0;
        rx_valid_q <= 1'b1;
        rx_data_q  <= mode_q.lsb_first ? bit_rev(rx_sr) : rx_sr;
      end

      if (state_q == IDLE) sclk_q <= cfg_cpol;

      if (accept) begin
        if (state_q == IDLE) begin
          mode_q   <= eff_mode;
          div_q    <= cfg_div;
          cs_sel_q <= cfg_cs_sel;
        end
        last_q    <= tx_last;
        bit_cnt_q <= BC_W'(DATA_W - 1);
        phase_q   <= 1'b0;
        // CPHA=0 presents the first bit during SETUP; CPHA=1 drives it on
        // the first leading edge.
        if (!eff_mode.cpha) begin
          mosi_q <= load_word[DATA_W-1];
          tx_sr  <= load_word << 1;
        end else begin
          tx_sr  <= load_word;
        end
      end

      if ((state_q == XFER) && tick) begin
        sclk_q  <= ~sclk_q;
        phase_q <= ~phase_q;
        // Sample edge is leading (phase 0) for CPHA=0, trailing for CPHA=1.
        if (phase_q == mode_q.cpha) begin
          rx_sr <= {rx_sr[DATA_W-2:0], spi_miso};
          if (bit_cnt_q == '0) rx_pend_q <= 1'b1;
        end else begin
          mosi_q <= tx_sr[DATA_W-1];
          tx_sr  <= tx_sr << 1;
        end
        if (phase_q && (bit_cnt_q != '0)) bit_cnt_q <= bit_cnt_q - 1'b1;
      end
    end
  end

  // Out-of-range selects match no line, so no chip select asserts.
  always_comb begin
    spi_cs_n = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_active && (int'(cs_sel_q) == i)) spi_cs_n[i] = 1'b0;
    end
  end

  assign spi_clk  = sclk_q;
  assign spi_mosi = mosi_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;

endmodule

// File: tb/tb_spi_master_multi.sv
module tb_spi_master_multi;

  localparam int DW  = 8;
  localparam int NCS = 3;
  localparam int CSW = 2;
  localparam int LOG = 256;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]     cfg_div = '0;
  logic           cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb_first = 1'b0;
  logic [CSW-1:0] cfg_cs_sel = '0;
  logic           tx_valid = 1'b0, tx_last = 1'b0;
  logic [DW-1:0]  tx_data = '0;
  logic           tx_ready, rx_valid, busy, spi_clk, spi_mosi, spi_miso;
  logic [DW-1:0]  rx_data;
  logic [NCS-1:0] spi_cs_n;

  logic           loopback = 1'b0;
  logic           slave_miso;
  assign spi_miso = loopback ? spi_mosi : slave_miso;

  spi_master_multi #(.DATA_W(DW), .NUM_CS(NCS), .DIV_W(8)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_lsb_first(cfg_lsb_first), .cfg_cs_sel(cfg_cs_sel), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid),
    .rx_data(rx_data), .busy(busy), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] tx_words[4];
  logic [DW-1:0] slave_words[4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = d[DW-1-i];
    return r;
  endfunction

  // ---------------- SPI slave model / bus monitor ----------------
  // Counts SPI clock edges per word and decides bit positions from the mode
  // rules alone; logs what the slave saw on MOSI and what the DUT reported.
  int            edges = 0, rises = 0, busy_cyc = 0, cs_low_cyc = 0;
  int            rx_cnt = 0, mosi_cnt = 0;
  int            cs_fall[NCS];
  logic [DW-1:0] rx_log[LOG];
  logic [DW-1:0] mosi_log[LOG];
  logic [DW-1:0] raw = '0;
  logic          m_cpha = 1'b0, m_lsb = 1'b0;
  logic          sclk_prev = 1'b0, busy_prev = 1'b0;
  logic [NCS-1:0] cs_prev = '1;

  initial begin
    slave_miso = 1'b0;
    for (int i = 0; i < NCS; i++) cs_fall[i] = 0;
  end

  always @(negedge clk) begin
    int k, w, bi;
    logic [DW-1:0] sw;
    if (rst) begin
      edges = 0;
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) begin
        m_cpha = cfg_cpha;
        m_lsb  = cfg_lsb_first;
        edges  = 0;
      end
      if (busy) begin
        busy_cyc++;
        if (spi_clk !== sclk_prev) begin
          edges++;
          if (spi_clk && !sclk_prev) rises++;
          k = (edges - 1) % (2 * DW) + 1;
          if (m_cpha ? (k % 2 == 0) : (k % 2 == 1)) begin
            bi  = (k - 1) / 2;
            raw = {raw[DW-2:0], spi_mosi};
            if (bi == DW - 1) begin
              mosi_log[mosi_cnt % LOG] = raw;
              mosi_cnt++;
            end
          end
        end
        k  = edges % (2 * DW);
        w  = edges / (2 * DW);
        bi = m_cpha ? ((k == 0) ? 0 : (k - 1) / 2) : k / 2;
        sw = slave_words[w % 4];
        slave_miso = m_lsb ? sw[bi] : sw[DW-1-bi];
      end
      busy_prev = busy;
    end
    sclk_prev = spi_clk;
    for (int i = 0; i < NCS; i++) if (cs_prev[i] && !spi_cs_n[i]) cs_fall[i]++;
    cs_prev = spi_cs_n;
    if (spi_cs_n != {NCS{1'b1}}) cs_low_cyc++;
    if (rx_valid) begin
      rx_log[rx_cnt % LOG] = rx_data;
      rx_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  int b_rx, b_mosi, b_rises, b_busy, b_low;
  int b_fall[NCS];

  task automatic snap();
    b_rx = rx_cnt; b_mosi = mosi_cnt; b_rises = rises; b_busy = busy_cyc; b_low = cs_low_cyc;
    for (int i = 0; i < NCS; i++) b_fall[i] = cs_fall[i];
  endtask

  task automatic set_cfg(input logic cpol, input logic cpha, input logic lsb,
                         input int div, input int sel);
    cfg_cpol = cpol; cfg_cpha = cpha; cfg_lsb_first = lsb;
    cfg_div = 8'(div); cfg_cs_sel = CSW'(sel);
    repeat (2) @(posedge clk);
    #1;
    check_eq("idle_clk_pre", 32'(spi_clk), 32'(cpol));
  endtask

  task automatic send_frame(input int n, input int gap);
    bit acc;
    for (int i = 0; i < n; i++) begin
      tx_data = tx_words[i]; tx_last = (i == n - 1); tx_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 2000 && !acc; c++) begin
        acc = tx_ready;
        @(posedge clk);
        #1;
      end
      tx_valid = 1'b0; tx_last = 1'b0;
      check_eq("tx_accept", 32'(acc), 32'd1);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk);
      #1;
      done = !busy;
    end
    check_eq("idle_timeout", 32'(done), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Compare one finished frame against the expected words and timing rules.
  task automatic check_frame(input int n, input int sel, input logic cpol,
                             input logic lsb, input int h);
    logic [DW-1:0] e;
    int tot;
    check_eq("rx_pulses", rx_cnt - b_rx, n);
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check_eq("rx_data", rx_log[(b_rx + i) % LOG], e);
    end
    check_eq("mosi_words", mosi_cnt - b_mosi, n);
    for (int i = 0; i < n; i++)
      check_eq("mosi_bits", mosi_log[(b_mosi + i) % LOG], lsb ? bitrev(tx_words[i]) : tx_words[i]);
    check_eq("sclk_rises", rises - b_rises, n * DW);
    check_eq("idle_clk_post", 32'(spi_clk), 32'(cpol));
    tot = 0;
    for (int j = 0; j < NCS; j++) begin
      check_eq("cs_fall_line", cs_fall[j] - b_fall[j], (j == sel) ? 1 : 0);
      tot += cs_fall[j] - b_fall[j];
    end
    check_eq("cs_fall_total", tot, (sel < NCS) ? 1 : 0);
    if (n == 1) begin
      check_eq("busy_cycles", busy_cyc - b_busy, (2 * DW + 3) * h);
      check_eq("cs_low_cycles", cs_low_cyc - b_low, (sel < NCS) ? (2 * DW + 2) * h : 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, sel, div, gap, seen;
    logic cpol, cpha, lsb;
    bit hit;

    // Reset values.
    #1;
    check_eq("rst_cs_n", 32'(spi_cs_n), 32'({NCS{1'b1}}));
    check_eq("rst_sclk", 32'(spi_clk), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    #21 rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ready_after_rst", 32'(tx_ready), 32'd1);

    // Mode 0 loopback, H=2.
    set_cfg(1'b0, 1'b0, 1'b0, 1, 0);
    loopback = 1'b1;
    tx_words[0] = 8'hA5;
    snap(); exp_q.push_back(8'hA5);
    send_frame(1, 0); wait_idle();
    check_frame(1, 0, 1'b0, 1'b0, 2);
    loopback = 1'b0;

    // Modes 1..3 against a slave returning 0x3C.
    for (int m = 1; m < 4; m++) begin
      set_cfg(m[1], m[0], 1'b0, 0, 2);
      tx_words[0] = 8'($urandom); slave_words[0] = 8'h3C;
      snap(); exp_q.push_back(8'h3C);
      send_frame(1, 0); wait_idle();
      check_frame(1, 2, m[1], 1'b0, 1);
    end

    // Three-word frame with 10-cycle gaps between words.
    set_cfg(1'b0, 1'b0, 1'b0, 0, 0);
    tx_words[0] = 8'h11; tx_words[1] = 8'h22; tx_words[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      slave_words[i] = 8'($urandom);
      exp_q.push_back(slave_words[i]);
    end
    snap(); send_frame(3, 10); wait_idle();
    check_frame(3, 0, 1'b0, 1'b0, 1);

    // LSB-first.
    set_cfg(1'b0, 1'b0, 1'b1, 1, 0);
    tx_words[0] = 8'h01; slave_words[0] = 8'h80;
    snap(); exp_q.push_back(8'h80);
    send_frame(1, 0); wait_idle();
    check_frame(1, 0, 1'b0, 1'b1, 2);

    // Chip select 1, divider changed mid-frame, then an out-of-range select.
    set_cfg(1'b0, 1'b0, 1'b0, 1, 1);
    tx_words[0] = 8'h5A; slave_words[0] = 8'hC3;
    snap(); exp_q.push_back(8'hC3);
    send_frame(1, 0);
    repeat (5) @(posedge clk);
    #1 cfg_div = 8'd3;
    wait_idle();
    check_frame(1, 1, 1'b0, 1'b0, 2);
    set_cfg(1'b0, 1'b0, 1'b0, 3, NCS);
    tx_words[0] = 8'h96; slave_words[0] = 8'h69;
    snap(); exp_q.push_back(8'h69);
    send_frame(1, 0); wait_idle();
    check_frame(1, NCS, 1'b0, 1'b0, 4);

    // Reset during bit 4.
    set_cfg(1'b0, 1'b0, 1'b0, 1, 0);
    tx_words[0] = 8'hF0; slave_words[0] = 8'h0F;
    snap(); send_frame(1, 0);
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(posedge clk);
      #1;
      hit = (rises - b_rises) >= 4;
    end
    check_eq("bit4_reached", 32'(hit), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_cs_n", 32'(spi_cs_n), 32'({NCS{1'b1}}));
    check_eq("midrst_sclk", 32'(spi_clk), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_tx_ready", 32'(tx_ready), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check_eq("midrst_no_rx", rx_cnt - b_rx, 0);
    check_eq("midrst_no_word", mosi_cnt - b_mosi, 0);
    set_cfg(1'b0, 1'b0, 1'b0, 1, 0);
    snap(); exp_q.push_back(8'h0F);
    send_frame(1, 0); wait_idle();
    check_frame(1, 0, 1'b0, 1'b0, 2);

    // Randomised frames.
    for (int t = 0; t < 12; t++) begin
      cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
      div  = $urandom_range(0, 3);
      sel  = $urandom_range(0, NCS - 1);
      n    = $urandom_range(1, 3);
      gap  = $urandom_range(0, 4);
      set_cfg(cpol, cpha, lsb, div, sel);
      for (int i = 0; i < n; i++) begin
        tx_words[i] = 8'($urandom);
        slave_words[i] = 8'($urandom);
        exp_q.push_back(slave_words[i]);
      end
      snap(); send_frame(n, gap); wait_idle();
      check_frame(n, sel, cpol, lsb, div + 1);
    end

    seen = exp_q.size();
    check_eq("exp_q_drained", seen, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
